// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the control unit: FSM state
// encoding, reset fetch address, instruction field positions and helpers.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // Opcode and funct field positions inside a 32-bit instruction word.
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter register with a redirect load and a sequential +4 step.
// A load takes priority over an increment; the increment wraps modulo 2^32.
module pc_counter
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic [31:0] load_target,
  input  logic        inc_en,
  output logic [31:0] pc
);

  logic [31:0] pc_seq;

  assign pc_seq = pc + PC_STEP;

  // PC update: reset, then redirect, then sequential advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load_en) begin
      pc <= word_align(load_target);
    end else if (inc_en) begin
      pc <= pc_seq;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Single-request instruction fetch stage. One word is requested, held for
// decode until accepted, then the next request is issued (no prefetch).
// A redirect while a request is outstanding leaves the request on the bus
// until it is acknowledged and throws the returned word away.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] instr,
  output logic [5:0]  inscod,
  output logic [5:0]  funct,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4
);

  fetch_state_t state_q, state_d;

  logic [31:0] pc;
  logic        pc_load;
  logic        pc_inc;
  logic        capture;
  // Address of the request on the bus; needed in DISCARD because the pc
  // register already holds the redirect target there.
  logic [31:0] req_addr_q;

  pc_counter #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .rst         (rst),
    .load_en     (pc_load),
    .load_target (branch_target),
    .inc_en      (pc_inc),
    .pc          (pc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and Moore outputs; memory acks are only looked at in
  // FETCH and DISCARD, so acks arriving in IDLE or HOLD fall through.
  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    imem_addr = 32'h0000_0000;
    dec_valid = 1'b0;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc;
        if (branch_en) begin
          pc_load = 1'b1;
          // An ack in the same cycle completes the old request, so the
          // redirected fetch can start straight away.
          state_d = imem_ack ? FETCH : DISCARD;
        end else if (imem_ack) begin
          capture = 1'b1;
          pc_inc  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        dec_valid = 1'b1;
        if (branch_en) begin
          pc_load = 1'b1;
          state_d = FETCH;
        end else if (dec_ready) begin
          state_d = FETCH;
        end
      end
      DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = req_addr_q;
        if (branch_en) begin
          pc_load = 1'b1;
        end
        if (imem_ack) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Track the outstanding request address while in FETCH.
  always_ff @(posedge clk) begin
    if (state_q == FETCH) begin
      req_addr_q <= pc;
    end
  end

  // Instruction holding register presented to decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr  <= 32'h0000_0000;
      pc_out <= 32'h0000_0000;
    end else if (capture) begin
      instr  <= imem_rdata;
      pc_out <= pc;
    end
  end

  assign inscod   = instr[OPCODE_MSB:OPCODE_LSB];
  assign funct    = instr[FUNCT_MSB:FUNCT_LSB];
  assign pc_plus4 = pc_out + PC_STEP;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the address of the first fetch after reset (bits [1:0] must be 0).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port imem_req, output, 1, instruction-memory request.
REQ-005 SHALL have port imem_addr, output, 32, word-aligned fetch address.
REQ-006 SHALL have port imem_ack, input, 1, memory response valid for the pending request.
REQ-007 SHALL have port imem_rdata, input, 32, instruction word; sampled only when imem_ack=1.
REQ-008 SHALL have port branch_en, input, 1, redirect request from execute.
REQ-009 SHALL have port branch_target, input, 32, redirect address; bits [1:0] ignored and treated as 0.
REQ-010 SHALL have port dec_valid, output, 1, instruction presented to decode.
REQ-011 SHALL have port dec_ready, input, 1, decode accepts the instruction this cycle.
REQ-012 SHALL have port instr, output, 32, the held instruction word.
REQ-013 SHALL have port inscod, output, 6, instr[31:26], the opcode field that feeds the control unit.
REQ-014 SHALL have port funct, output, 6, instr[5:0].
REQ-015 SHALL have port pc_out, output, 32, address of the held instruction.
REQ-016 SHALL have port pc_plus4, output, 32, pc_out + 4, modulo 2^32.

Function
REQ-017 SHALL implement the FSM states IDLE, FETCH, HOLD, and DISCARD.
REQ-018 IDLE: all outputs at their reset values; the next state is always FETCH.
REQ-019 FETCH: imem_req=1 and imem_addr=pc; imem_addr and imem_req SHALL stay stable until imem_ack.
REQ-020 FETCH with imem_ack=1 and branch_en=0: latch instr<=imem_rdata, pc_out<=pc, pc<=pc+4; go to HOLD; dec_valid=1 from the next cycle.
REQ-021 HOLD: imem_req=0 and dec_valid=1; instr, pc_out and pc_plus4 SHALL be stable until the handshake.
REQ-022 HOLD with dec_valid and dec_ready both 1: the transfer completes; go to FETCH; dec_valid=0 on the next cycle.
REQ-023 HOLD with branch_en=1: pc<=branch_target and go to FETCH; dec_valid=0 on the next cycle; this applies whether or not dec_ready=1 (a concurrent transfer still counts as completed).
REQ-024 FETCH with branch_en=1 and imem_ack=0: latch pc<=branch_target and go to DISCARD.
REQ-025 DISCARD: keep the original request (imem_req=1 and the original imem_addr) until imem_ack; drop the returned data; then go to FETCH at the redirected pc.
REQ-026 FETCH with branch_en=1 and imem_ack=1 in the same cycle: discard the data, pc<=branch_target, stay in FETCH; the next request is issued the following cycle.
REQ-027 DISCARD with a further branch_en: overwrite the latched target; the last redirect wins.
REQ-028 imem_ack in IDLE or HOLD SHALL be ignored.
REQ-029 The pc increment SHALL wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-030 Best-case throughput SHALL be one instruction per 2 cycles plus memory latency; there is no prefetch buffer.

Reset
REQ-031 With rst=1 at a clock edge: state<=IDLE, pc<=RESET_PC, instr<=0, pc_out<=0, imem_req=0, dec_valid=0; inscod, funct and pc_plus4 follow from these values.
REQ-032 Reset SHALL override any state, including a pending memory request; a late imem_ack after reset SHALL be ignored (it arrives in IDLE).

Structure
REQ-033 A shared package SHALL hold the state enum, RESET_PC default, and the opcode/funct bit-position constants; the control unit uses the same package.
REQ-034 The pc register and incrementer, with load-target and increment enables, SHALL be one sub-module named pc_counter; everything else lives in fetch_unit.

Verification
REQ-035 Reset, then imem_ack 1 cycle after each request with dec_ready=1 -> addresses 0, 4, 8 in order; instr/inscod match memory; dec_valid pulses once per instruction.
REQ-036 dec_ready held 0 for 5 cycles in HOLD -> instr and pc_out stable, imem_req=0, no new fetch until dec_ready=1.
REQ-037 branch_en with target 0x100 while a FETCH to 0x8 is pending (ack 3 cycles later) -> data for 0x8 never presented; next imem_addr=0x100.
REQ-038 branch_en and imem_ack in the same cycle -> data dropped; next request to target; target 0x103 fetched as 0x100.
REQ-039 RESET_PC=32'hFFFF_FFFC -> first fetch at FFFF_FFFC, pc_plus4=0, second fetch at 0.
REQ-040 rst asserted in DISCARD, then a stale imem_ack -> ignored; first fetch after reset at RESET_PC.
